// File: rtl/axi_ar_arbiter.sv
// Round-robin arbiter from decompressor read-request ports onto one shared AXI AR channel.
// Each grant pushes the one-hot requester select into the ID FIFO so R data can be steered back.
module axi_ar_arbiter #(
    parameter int NUM_DECOMPRESSOR = 2,
    parameter int ADDR_WIDTH       = 64,
    parameter int LEN_WIDTH        = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_DECOMPRESSOR-1:0]            req_valid,
    input  logic [NUM_DECOMPRESSOR*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_DECOMPRESSOR*LEN_WIDTH-1:0]  req_len,
    output logic [NUM_DECOMPRESSOR-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]                  m_araddr,
    output logic [LEN_WIDTH-1:0]                   m_arlen,
    output logic                                   m_arvalid,
    input  logic                                   m_arready,
    output logic [NUM_DECOMPRESSOR-1:0]            fifo_select,
    output logic                                   fifo_wr_en,
    input  logic                                   fifo_full
);
    localparam int IDX_W = (NUM_DECOMPRESSOR > 1) ? $clog2(NUM_DECOMPRESSOR) : 1;

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t                      state, next_state;
    logic [IDX_W-1:0]            last_grant;
    logic [IDX_W-1:0]            win_idx;
    logic [NUM_DECOMPRESSOR-1:0] win_oh;
    logic                        grant_ok;

    // Round-robin scan starting just after the last winner.
    always_comb begin
        int   idx;
        logic found;
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_DECOMPRESSOR; k++) begin
            idx = (int'(last_grant) + 1 + k) % NUM_DECOMPRESSOR;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
    end

    assign win_oh = NUM_DECOMPRESSOR'(1) << win_idx;

    // rst_n is folded in so nothing is accepted or pushed while reset is held.
    assign grant_ok = rst_n && !fifo_full && (|req_valid) &&
                      ((state == IDLE) || (state == ISSUE && m_arready));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            m_arvalid <= 1'b0;
        end else begin
            state     <= next_state;
            m_arvalid <= (next_state == ISSUE);
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_ok) next_state = ISSUE;
            ISSUE:   if (m_arready) next_state = grant_ok ? ISSUE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: accept, push and select all fire in the grant cycle only
    always_comb begin
        req_ready   = '0;
        fifo_select = '0;
        fifo_wr_en  = 1'b0;
        if (grant_ok) begin
            req_ready   = win_oh;
            fifo_select = win_oh;
            fifo_wr_en  = 1'b1;
        end
    end

    // AR payload and priority pointer only move on a grant, so they hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_araddr   <= '0;
            m_arlen    <= '0;
            last_grant <= IDX_W'(NUM_DECOMPRESSOR - 1);
        end else if (grant_ok) begin
            m_araddr   <= req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            m_arlen    <= req_len[int'(win_idx)*LEN_WIDTH +: LEN_WIDTH];
            last_grant <= win_idx;
        end
    end
endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Directed table-driven bench for axi_ar_arbiter (N=2) plus an ID-FIFO fill sequence.
module tb_axi_ar_arbiter;
    localparam int N  = 2;
    localparam int AW = 64;
    localparam int LW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*LW-1:0]   req_len;
    logic [N-1:0]      req_ready;
    logic [AW-1:0]     m_araddr;
    logic [LW-1:0]     m_arlen;
    logic              m_arvalid;
    logic              m_arready;
    logic [N-1:0]      fifo_select;
    logic              fifo_wr_en;
    logic              fifo_full;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_ar_arbiter #(.NUM_DECOMPRESSOR(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .fifo_select(fifo_select), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full)
    );

    typedef struct {
        logic          rst;
        logic [N-1:0]  rv;
        logic          ar;
        logic          full;
        logic [N-1:0]  e_rr;
        logic          e_we;
        logic          e_av;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_len;
    } vec_t;

    vec_t vecs[$];

    localparam logic [AW-1:0] A0 = 64'h1000;
    localparam logic [AW-1:0] A1 = 64'h2000;
    localparam logic [LW-1:0] L0 = 8'd7;
    localparam logic [LW-1:0] L1 = 8'd3;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = {A1, A0};
        req_len   = {L1, L0};
        m_arready = 1'b0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //            rst   rv     ar    full  e_rr   we    av    addr  len
        vecs.push_back('{1'b0, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 64'h0, 8'd0});  // reset state
        // single requester
        vecs.push_back('{1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 64'h0, 8'd0});
        vecs.push_back('{1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, A0,    L0  });
        vecs.push_back('{1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, A0,    L0  });
        // both requesting, arready high: one grant per cycle, alternating
        vecs.push_back('{1'b1, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, A0,    L0  });
        vecs.push_back('{1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, A1,    L1  });
        vecs.push_back('{1'b1, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, A0,    L0  });
        vecs.push_back('{1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, A1,    L1  });
        // AR stalled 5 cycles: payload held, no grants
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, A0, L0});
        vecs.push_back('{1'b1, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, A0,    L0  });
        // fifo_full blocks; in-flight AR completes, then grant resumes at last_grant+1
        vecs.push_back('{1'b1, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, A1,    L1  });
        vecs.push_back('{1'b1, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, A1,    L1  });
        vecs.push_back('{1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, A1,    L1  });
        // reset while ISSUE and stalled
        vecs.push_back('{1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, A0,    L0  });
        vecs.push_back('{1'b1, 2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 64'h0, 8'd0});
        vecs.push_back('{1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, A0,    L0  });
        vecs.push_back('{1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, A0,    L0  });

        foreach (vecs[i]) begin
            rst_n     = vecs[i].rst;
            req_valid = vecs[i].rv;
            m_arready = vecs[i].ar;
            fifo_full = vecs[i].full;
            #2;
            check($sformatf("v%0d req_ready", i),   AW'(req_ready),   AW'(vecs[i].e_rr));
            check($sformatf("v%0d fifo_select", i), AW'(fifo_select), AW'(vecs[i].e_rr));
            check($sformatf("v%0d fifo_wr_en", i),  AW'(fifo_wr_en),  AW'(vecs[i].e_we));
            check($sformatf("v%0d m_arvalid", i),   AW'(m_arvalid),   AW'(vecs[i].e_av));
            check($sformatf("v%0d m_araddr", i),    m_araddr,         vecs[i].e_addr);
            check($sformatf("v%0d m_arlen", i),     AW'(m_arlen),     AW'(vecs[i].e_len));
            @(posedge clk);
            #1;
        end

        // ID FIFO never popped: model holds 7 usable entries, so exactly 7 pushes then stall.
        begin
            int cnt;
            int expect_sel;
            cnt        = 0;
            expect_sel = 0;
            rst_n      = 1'b0;
            req_valid  = '0;
            m_arready  = 1'b1;
            fifo_full  = 1'b0;
            @(posedge clk);
            #1;
            rst_n     = 1'b1;
            req_valid = 2'b11;
            for (int c = 0; c < 12; c++) begin
                fifo_full = (cnt >= 7);
                #2;
                check($sformatf("fill c%0d fifo_wr_en", c), AW'(fifo_wr_en), AW'(cnt < 7));
                if (cnt < 7)
                    check($sformatf("fill c%0d fifo_select", c), AW'(fifo_select), AW'(2'b01 << expect_sel));
                if (fifo_wr_en) begin
                    cnt++;
                    expect_sel = 1 - expect_sel;
                end
                @(posedge clk);
                #1;
            end
            check("fill push count", AW'(cnt), AW'(7));
            #2;
            check("fill m_arvalid after drain", AW'(m_arvalid), AW'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
